// File: rtl/uart_sched_pkg.sv
// Shared types for the UART TX scheduler: drain/write FSM encodings and byte width.
package uart_sched_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    D_IDLE      = 3'd0,
    D_START     = 3'd1,
    D_WAIT_BUSY = 3'd2,
    D_WAIT_DONE = 3'd3,
    D_GAP       = 3'd4
  } drain_state_t;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: request vector + pointer -> one-hot grant and index.
// UART_SCHED_FIXED_PRIO_EN: requester 0 always wins; the others rotate and only they advance the pointer.
module uart_rr_arbiter #(
  parameter int N_REQ    = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                advance
);

  logic [N_REQ-1:0] rr_req;

  always_comb begin
    rr_req    = req;
`ifdef UART_SCHED_FIXED_PRIO_EN
    rr_req[0] = 1'b0;
`endif
    grant     = '0;
    grant_idx = '0;
    advance   = 1'b0;
    // Search from the pointer upwards first, then wrap to the indices below it.
    for (int i = 0; i < N_REQ; i++) begin
      if (!advance && rr_req[i] && (i >= int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = ID_WIDTH'(i);
        advance   = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!advance && rr_req[i] && (i < int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = ID_WIDTH'(i);
        advance   = 1'b1;
      end
    end
`ifdef UART_SCHED_FIXED_PRIO_EN
    if (req[0]) begin
      grant     = N_REQ'(1);
      grant_idx = '0;
      advance   = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART TX FIFO write port among N_REQ producers and paces FIFO drain into the transmitter.
// Build option UART_SCHED_FIXED_PRIO_EN (in uart_rr_arbiter) gives requester 0 fixed priority.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          N_REQ        = 2,
  parameter int          ID_WIDTH     = 1,
  parameter logic [15:0] BUSY_TIMEOUT = 16'd1000,
  parameter logic [7:0]  GAP_CYCLES   = 8'd4
) (
  input  logic                    sample_Clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_Valid,
  input  logic [N_REQ*BYTE_W-1:0] req_Data,
  output logic [N_REQ-1:0]        req_Ready,
  output logic                    wr_Sig,
  output logic [BYTE_W-1:0]       wr_Data,
  input  logic                    sig_Full,
  input  logic                    sig_Empty,
  output logic                    rd_Start,
  input  logic                    tx_Busy,
  output logic [ID_WIDTH-1:0]     grant_Id,
  output logic                    timeout_Err,
  output logic [2:0]              drain_State
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  wr_state_t             wr_state_q, wr_state_d;
  drain_state_t          d_state_q, d_state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [N_REQ-1:0]      arb_grant;
  logic [ID_WIDTH-1:0]   arb_idx;
  logic                  arb_adv;
  logic                  accept;
  logic [BYTE_W-1:0]     sel_byte;
  logic [15:0]           cnt_q, cnt_d;
  logic                  set_err;

  uart_rr_arbiter #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req       (req_Valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .advance   (arb_adv)
  );

  always_comb begin
    req_Ready = '0;
    if (!reset && (wr_state_q == W_IDLE) && !sig_Full) req_Ready = arb_grant;
  end

  assign accept = |req_Ready;

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) sel_byte = req_Data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    if (wr_state_q == W_IDLE) begin
      if (accept) wr_state_d = W_WRITE;
    end else begin
      wr_state_d = W_IDLE;
    end
  end

  always_ff @(posedge sample_Clk) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      rr_ptr_q   <= '0;
      wr_Data    <= '0;
      grant_Id   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      if (accept) begin
        wr_Data  <= sel_byte;
        grant_Id <= arb_idx;
        if (arb_adv)
          rr_ptr_q <= (arb_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : arb_idx + ID_WIDTH'(1);
      end
    end
  end

  assign wr_Sig = (wr_state_q == W_WRITE);

  // A drain start is only allowed when no write strobe lands in the same cycle as rd_Start.
  always_comb begin
    d_state_d = d_state_q;
    cnt_d     = cnt_q;
    set_err   = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (!sig_Empty && !tx_Busy && (wr_state_d != W_WRITE)) d_state_d = D_START;
      end
      D_START: begin
        cnt_d     = '0;
        d_state_d = D_WAIT_BUSY;
      end
      D_WAIT_BUSY: begin
        if (tx_Busy) begin
          d_state_d = D_WAIT_DONE;
        end else if (({1'b0, cnt_q} + 17'd1) >= {1'b0, BUSY_TIMEOUT}) begin
          set_err   = 1'b1;
          cnt_d     = '0;
          d_state_d = D_GAP;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      D_WAIT_DONE: begin
        if (!tx_Busy) begin
          cnt_d     = '0;
          d_state_d = D_GAP;
        end
      end
      D_GAP: begin
        if (({1'b0, cnt_q} + 17'd1) >= {9'd0, GAP_CYCLES}) d_state_d = D_IDLE;
        else cnt_d = sat_inc(cnt_q);
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge sample_Clk) begin
    if (reset) begin
      d_state_q   <= D_IDLE;
      cnt_q       <= '0;
      timeout_Err <= 1'b0;
    end else begin
      d_state_q <= d_state_d;
      cnt_q     <= cnt_d;
      if (set_err) timeout_Err <= 1'b1;
    end
  end

  assign rd_Start    = (d_state_q == D_START);
  assign drain_State = d_state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table, drain/timeout/collision sequences, random run vs model.
module tb_uart_tx_scheduler;

  localparam int N   = 2;
  localparam int GAP = 4;

  logic         sample_Clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_Valid;
  logic [N*8-1:0] req_Data;
  logic [N-1:0] req_Ready;
  logic         wr_Sig;
  logic [7:0]   wr_Data;
  logic         sig_Full, sig_Empty, rd_Start, tx_Busy;
  logic [0:0]   grant_Id;
  logic         timeout_Err;
  logic [2:0]   drain_State;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sample_Clk = ~sample_Clk;

  uart_tx_scheduler #(
    .N_REQ        (N),
    .ID_WIDTH     (1),
    .BUSY_TIMEOUT (16'd16),
    .GAP_CYCLES   (8'd4)
  ) dut (
    .sample_Clk  (sample_Clk),
    .reset       (reset),
    .req_Valid   (req_Valid),
    .req_Data    (req_Data),
    .req_Ready   (req_Ready),
    .wr_Sig      (wr_Sig),
    .wr_Data     (wr_Data),
    .sig_Full    (sig_Full),
    .sig_Empty   (sig_Empty),
    .rd_Start    (rd_Start),
    .tx_Busy     (tx_Busy),
    .grant_Id    (grant_Id),
    .timeout_Err (timeout_Err),
    .drain_State (drain_State)
  );

  typedef struct {
    logic [1:0] valid;
    logic       full;
    logic [1:0] ready;
    logic       wsig;
    logic [7:0] wdata;
    logic       gid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sample_Clk);
    #1;
  endtask

  task automatic add(input logic [1:0] v, input logic f, input logic [1:0] r,
                     input logic s, input logic [7:0] d, input logic g);
    vecs.push_back('{v, f, r, s, d, g});
  endtask

  // Reference arbitration from the rules: first valid at/after the pointer.
  function automatic int pick(input logic [1:0] v, input int p);
`ifdef UART_SCHED_FIXED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
`ifdef UART_SCHED_FIXED_PRIO_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  int first, second, fall, tmo_at, n_rd;
  int m_ptr, m_gid, g, bdly, blen, fall_c;
  logic m_pend, prev_busy;
  logic [7:0] m_data;
  logic [1:0] exp_ready;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_Valid = '0; req_Data = {8'h3C, 8'hA5};
    sig_Full = 1'b0; sig_Empty = 1'b1; tx_Busy = 1'b0;
    tick();
    req_Valid = 2'b11; sig_Empty = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rst_ready", 32'(req_Ready), 0);
      check("rst_wr_sig", 32'(wr_Sig), 0);
      check("rst_rd_start", 32'(rd_Start), 0);
      check("rst_drain_state", 32'(drain_State), 0);
      check("rst_timeout", 32'(timeout_Err), 0);
      check("rst_wr_data", 32'(wr_Data), 0);
      check("rst_grant", 32'(grant_Id), 0);
      tick();
    end
    reset = 1'b0; req_Valid = '0; sig_Empty = 1'b1;

`ifdef UART_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < 12; k++) begin
      req_Valid = 2'b11; sig_Full = 1'b0;
      #1;
      if (k % 2 == 0) begin
        check("fp_ready", 32'(req_Ready), 32'h1);
      end else begin
        check("fp_wr_sig", 32'(wr_Sig), 1);
        check("fp_grant", 32'(grant_Id), 0);
        check("fp_data", 32'(wr_Data), 32'hA5);
      end
      tick();
    end
`else
    add(2'b11, 0, 2'b01, 0, 8'h00, 0);
    add(2'b11, 0, 2'b00, 1, 8'hA5, 0);
    add(2'b11, 0, 2'b10, 0, 8'hA5, 0);
    add(2'b11, 0, 2'b00, 1, 8'h3C, 1);
    add(2'b11, 0, 2'b01, 0, 8'h3C, 1);
    add(2'b11, 0, 2'b00, 1, 8'hA5, 0);
    for (int k = 0; k < 10; k++) add(2'b11, 1, 2'b00, 0, 8'hA5, 0);
    add(2'b11, 0, 2'b10, 0, 8'hA5, 0);
    add(2'b11, 0, 2'b00, 1, 8'h3C, 1);
    add(2'b00, 0, 2'b00, 0, 8'h3C, 1);
    add(2'b01, 0, 2'b01, 0, 8'h3C, 1);
    add(2'b01, 0, 2'b00, 1, 8'hA5, 0);
    add(2'b01, 0, 2'b01, 0, 8'hA5, 0);
    add(2'b00, 0, 2'b00, 1, 8'hA5, 0);
    add(2'b10, 1, 2'b00, 0, 8'hA5, 0);
    add(2'b10, 0, 2'b10, 0, 8'hA5, 0);
    add(2'b00, 0, 2'b00, 1, 8'h3C, 1);
    foreach (vecs[i]) begin
      req_Valid = vecs[i].valid; sig_Full = vecs[i].full;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(req_Ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d_wr_sig", i), 32'(wr_Sig), 32'(vecs[i].wsig));
      check($sformatf("vec%0d_wr_data", i), 32'(wr_Data), 32'(vecs[i].wdata));
      check($sformatf("vec%0d_grant", i), 32'(grant_Id), 32'(vecs[i].gid));
      tick();
    end
`endif

    // Drain: busy rises 3 cycles after rd_Start and stays high 20 cycles.
    req_Valid = '0; sig_Full = 1'b0; sig_Empty = 1'b0;
    first = -1; second = -1; fall = -1;
    for (int c = 0; c < 300 && second < 0; c++) begin
      tx_Busy = (first >= 0 && c >= first + 3 && c < first + 23);
      if (first >= 0 && c == first + 23) fall = c;
      #1;
      if (rd_Start) begin
        if (first < 0) begin
          first = c;
          check("drain_start_state", 32'(drain_State), 1);
        end else begin
          second = c;
        end
      end
      if (first >= 0 && c == first + 1) check("drain_pulse_width", 32'(rd_Start), 0);
      if (first >= 0 && c == first + 12) check("drain_wait_done", 32'(drain_State), 3);
      tick();
    end
    check("drain_second_seen", 32'(second >= 0), 1);
    check("drain_one_per_frame", 32'(fall >= 0 && second >= fall), 1);
    check("drain_gap", 32'((second - fall) >= GAP), 1);

    // Timeout: busy never rises after the second rd_Start; FIFO reports empty meanwhile.
    sig_Empty = 1'b1; tx_Busy = 1'b0; tmo_at = -1; n_rd = 0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (timeout_Err && tmo_at < 0) tmo_at = k;
      if (rd_Start) n_rd++;
      if (k == 17) check("tmo_gap_state", 32'(drain_State), 4);
      if (k == 21) check("tmo_back_idle", 32'(drain_State), 0);
      tick();
    end
    check("tmo_cycle", 32'(tmo_at), 17);
    check("tmo_sticky", 32'(timeout_Err), 1);
    check("tmo_no_restart", 32'(n_rd), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("tmo_cleared", 32'(timeout_Err), 0);
    check("tmo_rst_state", 32'(drain_State), 0);
    tick();

    // Collision: the drain becomes eligible in the very cycle a byte is accepted.
    req_Valid = 2'b01; sig_Empty = 1'b0;
    #1;
    check("coll_accept", 32'(req_Ready), 32'h1);
    tick();
    req_Valid = '0;
    #1;
    check("coll_wr_sig", 32'(wr_Sig), 1);
    check("coll_rd_held", 32'(rd_Start), 0);
    tick();
    #1;
    check("coll_rd_start", 32'(rd_Start), 1);
    check("coll_wr_idle", 32'(wr_Sig), 0);
    tick();

    // Reset mid-frame with a byte offered in the reset cycle.
    reset = 1'b1; req_Valid = 2'b01;
    #1;
    check("rstmid_ready", 32'(req_Ready), 0);
    tick();
    reset = 1'b0; req_Valid = '0; sig_Empty = 1'b1;
    #1;
    check("rstmid_wr_sig", 32'(wr_Sig), 0);
    check("rstmid_rd_start", 32'(rd_Start), 0);
    check("rstmid_state", 32'(drain_State), 0);
    tick();

    // Random traffic against the reference model.
    m_ptr = 0; m_pend = 1'b0; m_data = '0; m_gid = 0;
    bdly = 0; blen = 0; fall_c = -1000; prev_busy = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req_Valid = 2'($urandom);
      req_Data  = 16'($urandom);
      sig_Full  = ($urandom_range(0, 3) == 0);
      sig_Empty = ($urandom_range(0, 2) == 0);
      if (blen > 0) begin
        tx_Busy = 1'b1;
        blen--;
      end else begin
        tx_Busy = 1'b0;
        if (bdly > 0) begin
          bdly--;
          if (bdly == 0) blen = $urandom_range(3, 10);
        end
      end
      if (prev_busy && !tx_Busy) fall_c = c;
      prev_busy = tx_Busy;
      #1;
      g = (m_pend || sig_Full) ? -1 : pick(req_Valid, m_ptr);
      exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
      check("rand_ready", 32'(req_Ready), 32'(exp_ready));
      check("rand_wr_sig", 32'(wr_Sig), 32'(m_pend));
      if (m_pend) begin
        check("rand_wr_data", 32'(wr_Data), 32'(m_data));
        check("rand_grant", 32'(grant_Id), 32'(m_gid));
      end
      check("rand_no_overlap", 32'(rd_Start & wr_Sig), 0);
      if (rd_Start) begin
        check("rand_gap", 32'((c - fall_c) >= GAP), 1);
        bdly = $urandom_range(1, 3);
      end
      if (g >= 0) begin
        m_pend = 1'b1;
        m_data = req_Data[g*8 +: 8];
        m_gid  = g;
`ifdef UART_SCHED_FIXED_PRIO_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end else begin
        m_pend = 1'b0;
      end
      tick();
    end
    #1;
    check("rand_no_timeout", 32'(timeout_Err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
